if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 28 ++
 rtl/if_stage.sv | 123 ++++++++++++
 tb/tb_if_stage.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// if_stage_pkg
//   Shared definitions for the instruction-fetch stage and the decode stage:
//   the fetch FSM state type, the bubble word, the PC increment and the
//   opcode values both stages agree on.
//   No ports (package).
package if_stage_pkg;

  typedef enum logic [0:0] {
    FETCH       = 1'b0,
    BRANCH_HOLD = 1'b1
  } if_state_e;

  // Bubble word: opcode field 7'b0000000, which decode treats as a no-op.
  localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0000;

  localparam logic [31:0] PC_INC = 32'd4;

  localparam logic [6:0] OPC_NOP    = 7'b0000000;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Force an address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage.sv
// if_stage
//   Instruction fetch: holds the PC, issues one read per cycle to the
//   instruction memory and registers the returned word for decode. When
//   decode flags the word being fetched as a branch, fetch parks in
//   BRANCH_HOLD (issuing bubbles) until the branch resolves or a hold
//   timeout forces a fall-through.
//
//   state       | meaning
//   ------------+--------------------------------------------------------
//   FETCH       | request imem at pc each unstalled cycle
//   BRANCH_HOLD | no requests; bubbles until branch_valid or timeout
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   stall                   freeze outputs and PC, suppress the request
//   pc_nop_control          current fetch is a branch -> enter BRANCH_HOLD
//   branch_valid/taken/target  branch resolution (used only in BRANCH_HOLD)
//   imem_req/addr           read request and word address
//   imem_ready/rdata        read data handshake
//   instruction/output_pc   registered word and its PC for decode
//   if_valid                instruction carries a real fetch
//   branch_timeout          one-cycle pulse when the hold timed out
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          HOLD_MAX  = 4,
  parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        pc_nop_control,
  input  logic        branch_valid,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] output_pc,
  output logic        if_valid,
  output logic        branch_timeout
);

  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(HOLD_MAX);

  if_state_e        state, state_nxt;
  logic [31:0]      pc, pc_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic             accept;
  logic             timeout_hit;

  // Gated by rst_n so no request escapes while reset is held.
  assign imem_req  = (state == FETCH) && !stall && rst_n;
  assign imem_addr = pc;
  assign accept    = imem_req && imem_ready;

  // A resolution arriving on the last hold cycle wins over the timeout.
  assign timeout_hit = (state == BRANCH_HOLD) && !branch_valid &&
                       (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    hold_cnt_nxt = hold_cnt;
    case (state)
      FETCH: begin
        // The flagged branch is itself fetched normally, so pc already
        // points at its fall-through when the hold starts.
        if (accept) pc_nxt = pc + PC_INC;
        if (pc_nop_control) begin
          state_nxt    = BRANCH_HOLD;
          hold_cnt_nxt = '0;
        end
      end
      BRANCH_HOLD: begin
        if (hold_cnt != HOLD_SAT) hold_cnt_nxt = hold_cnt + 1'b1;
        if (branch_valid) begin
          if (branch_taken) pc_nxt = align_word(branch_target);
          state_nxt = FETCH;
        end else if (timeout_hit) begin
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc             <= align_word(RESET_PC);
      hold_cnt       <= '0;
      instruction    <= NOP_INSTR;
      output_pc      <= 32'h0000_0000;
      if_valid       <= 1'b0;
      branch_timeout <= 1'b0;
    end else begin
      pc             <= pc_nxt;
      hold_cnt       <= hold_cnt_nxt;
      branch_timeout <= timeout_hit;
      if (!stall) begin
        if (accept) begin
          instruction <= imem_rdata;
          output_pc   <= pc;
          if_valid    <= 1'b1;
        end else begin
          instruction <= NOP_INSTR;
          if_valid    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] KEY = 32'h1357_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        pn = 1'b0;
  logic        bv = 1'b0;
  logic        bt = 1'b0;
  logic [31:0] tgt = 32'h0;
  logic        ready = 1'b1;

  logic        req0, req1, v0, v1, to0, to1;
  logic [31:0] addr0, addr1, rdata0, rdata1, instr0, instr1, opc0, opc1;

  int sel = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory model: each word is its address scrambled by a fixed key.
  assign rdata0 = addr0 ^ KEY;
  assign rdata1 = addr1 ^ KEY;

  if_stage #(.RESET_PC(32'h0000_0000), .HOLD_MAX(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pc_nop_control(pn),
    .branch_valid(bv), .branch_taken(bt), .branch_target(tgt),
    .imem_req(req0), .imem_addr(addr0), .imem_ready(ready), .imem_rdata(rdata0),
    .instruction(instr0), .output_pc(opc0), .if_valid(v0), .branch_timeout(to0)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC), .HOLD_MAX(4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pc_nop_control(pn),
    .branch_valid(bv), .branch_taken(bt), .branch_target(tgt),
    .imem_req(req1), .imem_addr(addr1), .imem_ready(ready), .imem_rdata(rdata1),
    .instruction(instr1), .output_pc(opc1), .if_valid(v1), .branch_timeout(to1)
  );

  // v: 0 bubble, 1 real fetch of pc, 2 reset state (output_pc must be 0)
  typedef struct {
    int          sel;
    int          v;
    logic [31:0] pc;
    logic        t;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b at %0t", name, got, exp, $time);
    end
  endtask

  // Called just after a negedge with inputs already set. Checks the
  // combinational request, queues the expected registered result of the
  // coming edge, and returns at the next negedge.
  task automatic step(input int ereq, input logic [31:0] eaddr, input int ev,
                      input logic [31:0] epc, input logic et);
    exp_t e;
    #1;
    if (ereq >= 0) begin
      chk1("imem_req", (sel == 1) ? req1 : req0, ereq == 1);
      if (ereq == 1) chk32("imem_addr", (sel == 1) ? addr1 : addr0, eaddr);
    end
    e.sel = sel;
    e.v   = ev;
    e.pc  = epc;
    e.t   = et;
    sb.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk1("if_valid", (mon_e.sel == 1) ? v1 : v0, mon_e.v == 1);
      chk32("instruction", (mon_e.sel == 1) ? instr1 : instr0,
            (mon_e.v == 1) ? (mon_e.pc ^ KEY) : NOP);
      if (mon_e.v == 1) chk32("output_pc", (mon_e.sel == 1) ? opc1 : opc0, mon_e.pc);
      if (mon_e.v == 2) chk32("output_pc_reset", (mon_e.sel == 1) ? opc1 : opc0, 32'h0);
      chk1("branch_timeout", (mon_e.sel == 1) ? to1 : to0, mon_e.t);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    // reset state
    step(0, 0, 2, 0, 0);
    rst_n = 1'b1;
    // streaming fetch, ready always high
    step(1, 32'h00, 1, 32'h00, 0);
    step(1, 32'h04, 1, 32'h04, 0);
    step(1, 32'h08, 1, 32'h08, 0);
    step(1, 32'h0C, 1, 32'h0C, 0);
    // re-reset, then memory not ready for two cycles at pc=8
    rst_n = 1'b0;
    step(0, 0, 2, 0, 0);
    rst_n = 1'b1;
    step(1, 32'h00, 1, 32'h00, 0);
    step(1, 32'h04, 1, 32'h04, 0);
    ready = 1'b0;
    step(1, 32'h08, 0, 0, 0);
    step(1, 32'h08, 0, 0, 0);
    ready = 1'b1;
    step(1, 32'h08, 1, 32'h08, 0);
    step(1, 32'h0C, 1, 32'h0C, 0);
    // branch at 0x10, resolved taken to 0x43 two cycles later
    pn = 1'b1;
    step(1, 32'h10, 1, 32'h10, 0);
    pn = 1'b0;
    step(0, 0, 0, 0, 0);
    bv = 1'b1; bt = 1'b1; tgt = 32'h43;
    step(0, 0, 0, 0, 0);
    bv = 1'b0; bt = 1'b0;
    step(1, 32'h40, 1, 32'h40, 0);
    // resolution outside the hold is ignored
    bv = 1'b1; bt = 1'b1; tgt = 32'h100;
    step(1, 32'h44, 1, 32'h44, 0);
    bv = 1'b0; bt = 1'b0;
    step(1, 32'h48, 1, 32'h48, 0);
    // branch at 0x4C, resolved taken to 0x1E -> 0x1C
    pn = 1'b1;
    step(1, 32'h4C, 1, 32'h4C, 0);
    pn = 1'b0; bv = 1'b1; bt = 1'b1; tgt = 32'h1E;
    step(0, 0, 0, 0, 0);
    bv = 1'b0; bt = 1'b0;
    step(1, 32'h1C, 1, 32'h1C, 0);
    // branch at 0x20, never resolved -> 4 bubbles, timeout, fall-through
    pn = 1'b1;
    step(1, 32'h20, 1, 32'h20, 0);
    pn = 1'b0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(1, 32'h24, 1, 32'h24, 0);
    // resolution on the timeout cycle, with pc_nop_control also high
    pn = 1'b1;
    step(1, 32'h28, 1, 32'h28, 0);
    pn = 1'b0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    pn = 1'b1; bv = 1'b1; bt = 1'b1; tgt = 32'h80;
    step(0, 0, 0, 0, 0);
    pn = 1'b0; bv = 1'b0; bt = 1'b0;
    step(1, 32'h80, 1, 32'h80, 0);
    // not-taken resolution keeps the fall-through pc
    pn = 1'b1;
    step(1, 32'h84, 1, 32'h84, 0);
    pn = 1'b0; bv = 1'b1; bt = 1'b0; tgt = 32'h200;
    step(0, 0, 0, 0, 0);
    bv = 1'b0;
    step(1, 32'h88, 1, 32'h88, 0);
    // stall for three cycles: outputs frozen, no request
    stall = 1'b1;
    step(0, 0, 1, 32'h88, 0);
    step(0, 0, 1, 32'h88, 0);
    step(0, 0, 1, 32'h88, 0);
    stall = 1'b0;
    step(1, 32'h8C, 1, 32'h8C, 0);
    // top-of-memory reset PC wraps; reset during a hold discards it
    sel = 1;
    rst_n = 1'b0;
    step(0, 0, 2, 0, 0);
    rst_n = 1'b1;
    step(1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0);
    step(1, 32'h0000_0000, 1, 32'h0000_0000, 0);
    pn = 1'b1;
    step(1, 32'h0000_0004, 1, 32'h0000_0004, 0);
    pn = 1'b0;
    step(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    step(0, 0, 2, 0, 0);
    rst_n = 1'b1;
    step(1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0);
    step(1, 32'h0000_0000, 1, 32'h0000_0000, 0);

    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0 entries left", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
